// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   Groups every signal between the two requesters (CPU, DMA), the
//   single-port memory, and the arbiter that sits between them.
//
//   Modports
//     slave  : the arbiter's view. Requests and memory responses come in;
//              grants, done pulses, read data and memory strobes go out.
//     master : the environment's view (CPUs, DMA engine, memory model,
//              testbench). It is the mirror image of slave.
//
//   Signal summary
//     cpu_req/cpu_we/cpu_addr[15:0]/cpu_wdata[7:0] : CPU cycle request
//     dma_req/dma_we/dma_addr[15:0]/dma_wdata[7:0] : DMA cycle request
//     cpu_grant/dma_grant   : requester owns the bus
//     cpu_done/dma_done     : one-cycle completion pulse to the owner
//     rdata[7:0]            : read data, valid in the done cycle
//     bus_error             : one-cycle pulse with done on a memory timeout
//     mem_addr/mem_wdata    : memory address and write data
//     mem_re/mem_we         : memory read / write strobes
//     mem_rdata/mem_ready   : memory read data and access-complete flag
// ---------------------------------------------------------------------------
interface bus_arbiter_if;

  // CPU request side
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  // DMA request side
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  // Responses to the requesters
  logic        cpu_grant;
  logic        dma_grant;
  logic        cpu_done;
  logic        dma_done;
  logic [7:0]  rdata;
  logic        bus_error;

  // Memory side
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ready,
    output cpu_grant, dma_grant, cpu_done, dma_done, rdata, bus_error,
    output mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ready,
    input  cpu_grant, dma_grant, cpu_done, dma_done, rdata, bus_error,
    input  mem_addr, mem_wdata, mem_re, mem_we
  );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-requester (CPU, DMA) arbiter in front of a single memory port.
//   A three-state FSM (IDLE -> ACCESS -> DONE -> IDLE) runs one access at a
//   time. Ties are broken in favour of whichever requester did not own the
//   bus last. Every output is a flop; the combinational process computes the
//   next value of each output alongside the next state.
//
//   Parameters
//     WAIT_STATES : ACCESS cycles that must elapse before mem_ready counts
//     TIMEOUT     : further ACCESS cycles allowed before the access is
//                   aborted with rdata = 8'hFF and bus_error
//
//   Ports
//     clk   : sole clock, all state changes on its rising edge
//     rst_n : asynchronous active-low reset
//     bus   : bus_arbiter_if.slave, requester/memory signal bundle
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Counter value at which a still-unready access is abandoned.
  localparam int TIMEOUT_LIMIT = WAIT_STATES + TIMEOUT;

  // FSM and bookkeeping state
  state_e      state_q,      state_d;
  owner_e      owner_q,      owner_d;
  owner_e      last_owner_q, last_owner_d;
  logic        we_q,         we_d;
  logic [7:0]  cnt_q,        cnt_d;

  // Registered outputs
  logic        cpu_grant_q,  cpu_grant_d;
  logic        dma_grant_q,  dma_grant_d;
  logic        cpu_done_q,   cpu_done_d;
  logic        dma_done_q,   dma_done_d;
  logic        bus_error_q,  bus_error_d;
  logic        mem_re_q,     mem_re_d;
  logic        mem_we_q,     mem_we_d;
  logic [15:0] mem_addr_q,   mem_addr_d;
  logic [7:0]  mem_wdata_q,  mem_wdata_d;
  logic [7:0]  rdata_q,      rdata_d;

  // Decision helpers
  logic        cpu_wins;
  logic        wait_met;
  logic        timed_out;

  // NOTE: state is written with <= so every flop samples the values from
  // before the edge; blocking assignments here would create order-dependent
  // simulation results that do not match the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DMA;
      last_owner_q <= OWN_DMA;  // CPU wins the first tie after reset
      we_q         <= 1'b0;
      cnt_q        <= 8'd0;
      cpu_grant_q  <= 1'b0;
      dma_grant_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      dma_done_q   <= 1'b0;
      bus_error_q  <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'd0;
      mem_wdata_q  <= 8'd0;
      rdata_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      cpu_grant_q  <= cpu_grant_d;
      dma_grant_q  <= dma_grant_d;
      cpu_done_q   <= cpu_done_d;
      dma_done_q   <= dma_done_d;
      bus_error_q  <= bus_error_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // A lone CPU request wins; on a tie the CPU wins only if DMA went last.
  assign cpu_wins  = bus.cpu_req && (!bus.dma_req || (last_owner_q == OWN_DMA));
  assign wait_met  = int'(cnt_q) >= WAIT_STATES;
  assign timed_out = int'(cnt_q) >= TIMEOUT_LIMIT;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    cpu_grant_d  = 1'b0;
    dma_grant_d  = 1'b0;
    cpu_done_d   = 1'b0;
    dma_done_d   = 1'b0;
    bus_error_d  = 1'b0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          // Latch the winner's command now; outputs for the first ACCESS
          // cycle are computed here so they appear right on entry.
          state_d = ST_ACCESS;
          cnt_d   = 8'd0;
          if (cpu_wins) begin
            owner_d      = OWN_CPU;
            last_owner_d = OWN_CPU;
            we_d         = bus.cpu_we;
            mem_addr_d   = bus.cpu_addr;
            mem_wdata_d  = bus.cpu_wdata;
            cpu_grant_d  = 1'b1;
            mem_re_d     = !bus.cpu_we;
            mem_we_d     = bus.cpu_we;
          end else begin
            owner_d      = OWN_DMA;
            last_owner_d = OWN_DMA;
            we_d         = bus.dma_we;
            mem_addr_d   = bus.dma_addr;
            mem_wdata_d  = bus.dma_wdata;
            dma_grant_d  = 1'b1;
            mem_re_d     = !bus.dma_we;
            mem_we_d     = bus.dma_we;
          end
        end
      end

      ST_ACCESS: begin
        // Grant is held through ACCESS and the following DONE cycle.
        cpu_grant_d = (owner_q == OWN_CPU);
        dma_grant_d = (owner_q == OWN_DMA);
        cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        if (wait_met && bus.mem_ready) begin
          state_d    = ST_DONE;
          cpu_done_d = (owner_q == OWN_CPU);
          dma_done_d = (owner_q == OWN_DMA);
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else if (timed_out) begin
          state_d     = ST_DONE;
          cpu_done_d  = (owner_q == OWN_CPU);
          dma_done_d  = (owner_q == OWN_DMA);
          bus_error_d = 1'b1;
          rdata_d     = 8'hFF;
        end else begin
          // Early mem_ready (before WAIT_STATES) lands here and is ignored.
          mem_re_d = !we_q;
          mem_we_d = we_q;
        end
      end

      ST_DONE: begin
        // Grants drop with the return to IDLE, forcing at least one idle
        // cycle between back-to-back accesses.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cpu_grant = cpu_grant_q;
  assign bus.dma_grant = dma_grant_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.bus_error = bus_error_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter. dut uses the default parameters
//   (WAIT_STATES=1, TIMEOUT=15); dut3 uses WAIT_STATES=3 for the early-ready
//   case. Inputs change 1 time unit after the rising edge and outputs are
//   read at that same point, well away from the edge itself.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bus_arbiter_if bus  ();
  bus_arbiter_if bus3 ();

  bus_arbiter #(.WAIT_STATES(1), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bus_arbiter #(.WAIT_STATES(3), .TIMEOUT(15)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req  = 1'b0; bus.cpu_we  = 1'b0; bus.cpu_addr  = 16'd0; bus.cpu_wdata = 8'd0;
    bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = 16'd0; bus.dma_wdata = 8'd0;
    bus.mem_rdata = 8'd0; bus.mem_ready = 1'b0;
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = 16'd0; bus3.cpu_wdata = 8'd0;
    bus3.dma_req = 1'b0; bus3.dma_we = 1'b0; bus3.dma_addr = 16'd0; bus3.dma_wdata = 8'd0;
    bus3.mem_rdata = 8'd0; bus3.mem_ready = 1'b0;
  endtask

  // Advance until the main DUT raises a done, counting strobe cycles seen
  // on the way. found=0 if the budget runs out first.
  task automatic wait_done(input int budget, output int re_cycles,
                           output int we_cycles, output bit found);
    re_cycles = 0;
    we_cycles = 0;
    found     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.cpu_done || bus.dma_done) begin
        found = 1'b1;
        break;
      end
      if (bus.mem_re) re_cycles++;
      if (bus.mem_we) we_cycles++;
    end
  endtask

  initial begin
    int  re_n;
    int  we_n;
    bit  found;
    int  n_done;
    int  overlap;
    logic [3:0] seq;

    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_ctrl", {bus.cpu_grant, bus.dma_grant, bus.cpu_done, bus.dma_done,
                       bus.mem_re, bus.mem_we, bus.bus_error}, 7'b0);
    check("rst_addr",  bus.mem_addr,  16'h0000);
    check("rst_wdata", bus.mem_wdata, 8'h00);
    check("rst_rdata", bus.rdata,     8'h00);

    // ---- single CPU read, requested in the first cycle after release ----
    rst_n         = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h1234;
    bus.mem_rdata = 8'hA5;
    bus.mem_ready = 1'b1;
    tick();  // N+1
    check("rd_n1_grant", {bus.cpu_grant, bus.dma_grant}, 2'b10);
    check("rd_n1_strb",  {bus.mem_re, bus.mem_we}, 2'b10);
    check("rd_n1_addr",  bus.mem_addr, 16'h1234);
    bus.cpu_req = 1'b0;
    tick();  // N+2
    check("rd_n2_strb", {bus.mem_re, bus.cpu_done}, 2'b10);
    tick();  // N+3
    check("rd_n3_done", {bus.cpu_done, bus.cpu_grant, bus.mem_re, bus.bus_error}, 4'b1100);
    check("rd_n3_rdata", bus.rdata, 8'hA5);
    tick();  // N+4
    check("rd_n4_idle", {bus.cpu_done, bus.cpu_grant}, 2'b00);

    // ---- tie after reset: CPU, DMA, CPU, DMA ----
    rst_n = 1'b0;
    tick();
    check("rst2_rdata", bus.rdata, 8'h00);
    rst_n         = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.dma_req   = 1'b1;
    bus.cpu_addr  = 16'h0100;
    bus.dma_addr  = 16'h0200;
    bus.mem_rdata = 8'h3C;
    bus.mem_ready = 1'b1;
    n_done  = 0;
    overlap = 0;
    seq     = 4'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((bus.cpu_grant && bus.dma_grant) ||
          (bus.cpu_done && !bus.cpu_grant) || (bus.dma_done && !bus.dma_grant))
        overlap++;
      if (bus.cpu_done || bus.dma_done) begin
        seq = {seq[2:0], bus.dma_done};
        n_done++;
      end
      if (n_done == 4) begin
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        break;
      end
    end
    check("tie_count",   n_done, 4);
    check("tie_order",   seq, 4'b0101);
    check("tie_overlap", overlap, 0);
    tick();
    tick();

    // ---- DMA write, mem_ready low for 3 extra cycles ----
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 16'hBEEF;
    bus.dma_wdata = 8'h5A;
    bus.mem_ready = 1'b0;
    tick();  // ACCESS cnt 0
    check("wr_grant", {bus.cpu_grant, bus.dma_grant}, 2'b01);
    check("wr_strb",  {bus.mem_re, bus.mem_we}, 2'b01);
    check("wr_addr",  bus.mem_addr, 16'hBEEF);
    check("wr_wdata", bus.mem_wdata, 8'h5A);
    bus.dma_req = 1'b0;
    tick();  // cnt 1
    tick();  // cnt 2
    tick();  // cnt 3
    check("wr_wait", {bus.mem_we, bus.dma_done}, 2'b10);
    tick();  // cnt 4, ready now
    bus.mem_ready = 1'b1;
    check("wr_ready_cyc", {bus.mem_we, bus.dma_done}, 2'b10);
    tick();
    check("wr_done", {bus.dma_done, bus.dma_grant, bus.mem_we, bus.bus_error}, 4'b1100);
    check("wr_rdata_kept", bus.rdata, 8'h3C);
    bus.dma_we = 1'b0;
    tick();
    tick();

    // ---- timeout: mem_ready never rises ----
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0F0F;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h11;
    wait_done(40, re_n, we_n, found);
    check("to_seen",  found, 1'b1);
    check("to_cycles", re_n, 17);
    check("to_flags", {bus.cpu_done, bus.bus_error, bus.mem_re}, 3'b110);
    check("to_rdata", bus.rdata, 8'hFF);
    bus.cpu_req = 1'b0;
    tick();
    check("to_err_pulse", {bus.bus_error, bus.cpu_done}, 2'b00);
    tick();

    // ---- reset during ACCESS, then a fresh access ----
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 16'h7777;
    bus.mem_ready = 1'b0;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    tick();
    check("mid_pre", {bus.cpu_grant, bus.mem_re}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("mid_drop", {bus.cpu_grant, bus.mem_re, bus.cpu_done, bus.mem_addr}, 19'd0);
    tick();
    check("mid_nodone", {bus.cpu_done, bus.dma_done, bus.cpu_grant}, 3'b000);
    rst_n         = 1'b1;
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 16'h4242;
    bus.mem_rdata = 8'h77;
    bus.mem_ready = 1'b1;
    tick();
    check("post_grant", {bus.dma_grant, bus.mem_re, bus.mem_addr}, {2'b11, 16'h4242});
    bus.dma_req = 1'b0;
    tick();
    tick();
    check("post_done",  {bus.dma_done, bus.bus_error}, 2'b10);
    check("post_rdata", bus.rdata, 8'h77);
    tick();

    // ---- WAIT_STATES=3 with mem_ready high from the start ----
    bus3.cpu_req   = 1'b1;
    bus3.cpu_we    = 1'b0;
    bus3.cpu_addr  = 16'hABCD;
    bus3.mem_rdata = 8'h99;
    bus3.mem_ready = 1'b1;
    re_n  = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus3.cpu_req = 1'b0;
      if (bus3.cpu_done) begin
        found = 1'b1;
        break;
      end
      if (bus3.mem_re) re_n++;
    end
    check("ws3_seen",   found, 1'b1);
    check("ws3_cycles", re_n, 4);
    check("ws3_rdata",  bus3.rdata, 8'h99);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_arbiter
